// File: rtl/lbist_pkg.sv
// -----------------------------------------------------------------------------
// lbist_pkg
// Shared definitions for the LBIST output response analyzer:
//   - state_t      : session FSM encoding (IDLE, RUN, COMPARE, DONE)
//   - DEF_*        : default MISR width, session length, feedback taps and seed
// -----------------------------------------------------------------------------
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // x^4 + x + 1 feedback taps for the default 4-bit MISR
    localparam int unsigned DEF_OUT_BITS = 32'd4;
    localparam int unsigned DEF_PAT_CNT  = 32'd16;
    localparam int unsigned DEF_POLY     = 32'h0000_0003;
    localparam int unsigned DEF_SEED     = 32'h0000_0000;

endpackage : lbist_pkg

// File: rtl/misr_ora_misr.sv
// -----------------------------------------------------------------------------
// misr
// Multiple-input signature register. Each enabled edge folds one data word
// into the signature: next = (sig << 1) ^ (sig msb ? POLY : 0) ^ din.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      synchronous reset, active high (sig <= SEED)
//   load  in  1      reload SEED; wins over en
//   en    in  1      compact din into the signature this edge
//   din   in  WIDTH  data word to compact
//   sig   out WIDTH  current signature (registered)
// -----------------------------------------------------------------------------
module misr
    import lbist_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_OUT_BITS,
    parameter int unsigned POLY  = DEF_POLY,
    parameter int unsigned SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    localparam logic [WIDTH-1:0] POLY_V = WIDTH'(POLY);
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    // One compaction step of the Galois-style MISR
    function automatic logic [WIDTH-1:0] misr_step(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] data
    );
        logic [WIDTH-1:0] fb;
        fb = cur[WIDTH-1] ? POLY_V : {WIDTH{1'b0}};
        return (cur << 1) ^ fb ^ data;
    endfunction

    logic [WIDTH-1:0] sig_r;

    // Signature register: reset/load to seed, otherwise compact when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_r <= SEED_V;
        end else if (load) begin
            sig_r <= SEED_V;
        end else if (en) begin
            sig_r <= misr_step(sig_r, din);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign sig = sig_r;

endmodule : misr

// File: rtl/misr_ora.sv
// -----------------------------------------------------------------------------
// misr_ora
// LBIST output response analyzer. Compacts circuit-under-test and fault-free
// responses over a PAT_CNT-beat session in two parallel MISRs, compares the
// final signatures, and counts raw per-beat mismatches so that a signature
// match hiding real mismatches (aliasing) is flagged.
// Ports:
//   clk             in   1         clock, rising edge
//   rst             in   1         synchronous reset, active high
//   start           in   1         begin a session (only in IDLE/DONE)
//   in_valid        in   1         CUT_OP/FF_OP beat valid
//   CUT_OP          in   OUT_BITS  circuit-under-test output
//   FF_OP           in   OUT_BITS  fault-free output
//   busy            out  1         session in RUN or COMPARE
//   done            out  1         results valid and held
//   RES             out  1         final signatures differ
//   ALIAS           out  1         signatures equal but some beat mismatched
//   SIG             out  OUT_BITS  CUT MISR signature
//   mismatch_cnt    out  CNT_W     beats with CUT_OP != FF_OP
//   first_fail_idx  out  IDX_W     index of first mismatching beat
// -----------------------------------------------------------------------------
module misr_ora
    import lbist_pkg::*;
#(
    parameter  int unsigned OUT_BITS = DEF_OUT_BITS,
    parameter  int unsigned PAT_CNT  = DEF_PAT_CNT,
    parameter  int unsigned POLY     = DEF_POLY,
    parameter  int unsigned SEED     = DEF_SEED,
    localparam int unsigned CNT_W    = $clog2(PAT_CNT + 1),
    localparam int unsigned IDX_W    = (PAT_CNT > 1) ? $clog2(PAT_CNT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    output logic                busy,
    output logic                done,
    output logic                RES,
    output logic                ALIAS,
    output logic [OUT_BITS-1:0] SIG,
    output logic [CNT_W-1:0]    mismatch_cnt,
    output logic [IDX_W-1:0]    first_fail_idx
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PAT_CNT - 1);

    state_t                state_r;
    state_t                next_state_s;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic [CNT_W-1:0]      mismatch_cnt_r;
    logic [IDX_W-1:0]      first_fail_idx_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  res_r;
    logic                  alias_r;
    logic [OUT_BITS-1:0]   sig_cut_s;
    logic [OUT_BITS-1:0]   sig_ff_s;
    logic                  start_sess_s;
    logic                  accept_s;
    logic                  last_beat_s;
    logic                  beat_miss_s;

    // start is only honoured between sessions; in_valid only counts in RUN
    assign start_sess_s = start && ((state_r == IDLE) || (state_r == DONE));
    assign accept_s     = in_valid && (state_r == RUN);
    assign last_beat_s  = accept_s && (beat_cnt_r == LAST_BEAT);
    assign beat_miss_s  = (CUT_OP != FF_OP);

    misr #(
        .WIDTH (OUT_BITS),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr_cut (
        .clk  (clk),
        .rst  (rst),
        .load (start_sess_s),
        .en   (accept_s),
        .din  (CUT_OP),
        .sig  (sig_cut_s)
    );

    misr #(
        .WIDTH (OUT_BITS),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr_ff (
        .clk  (clk),
        .rst  (rst),
        .load (start_sess_s),
        .en   (accept_s),
        .din  (FF_OP),
        .sig  (sig_ff_s)
    );

    // Session FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Session FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_beat_s) begin
                    next_state_s = COMPARE;
                end else begin
                    next_state_s = RUN;
                end
            end
            COMPARE: begin
                next_state_s = DONE;
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // busy is registered from the next state so it tracks RUN/COMPARE exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == RUN) || (next_state_s == COMPARE);
        end
    end

    // Beat counter and raw mismatch tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r       <= {CNT_W{1'b0}};
            mismatch_cnt_r   <= {CNT_W{1'b0}};
            first_fail_idx_r <= {IDX_W{1'b0}};
        end else if (start_sess_s) begin
            beat_cnt_r       <= {CNT_W{1'b0}};
            mismatch_cnt_r   <= {CNT_W{1'b0}};
            first_fail_idx_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
            if (beat_miss_s) begin
                mismatch_cnt_r <= mismatch_cnt_r + CNT_W'(1);
                // Only the first mismatch of the session records its index
                if (mismatch_cnt_r == {CNT_W{1'b0}}) begin
                    first_fail_idx_r <= IDX_W'(beat_cnt_r);
                end else begin
                    first_fail_idx_r <= first_fail_idx_r;
                end
            end else begin
                mismatch_cnt_r   <= mismatch_cnt_r;
                first_fail_idx_r <= first_fail_idx_r;
            end
        end else begin
            beat_cnt_r       <= beat_cnt_r;
            mismatch_cnt_r   <= mismatch_cnt_r;
            first_fail_idx_r <= first_fail_idx_r;
        end
    end

    // Result registers: cleared at session start, set on leaving COMPARE
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r  <= 1'b0;
            res_r   <= 1'b0;
            alias_r <= 1'b0;
        end else if (start_sess_s) begin
            done_r  <= 1'b0;
            res_r   <= 1'b0;
            alias_r <= 1'b0;
        end else if (state_r == COMPARE) begin
            done_r  <= 1'b1;
            res_r   <= (sig_cut_s != sig_ff_s);
            alias_r <= (sig_cut_s == sig_ff_s) && (mismatch_cnt_r != {CNT_W{1'b0}});
        end else begin
            done_r  <= done_r;
            res_r   <= res_r;
            alias_r <= alias_r;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign RES            = res_r;
    assign ALIAS          = alias_r;
    assign SIG            = sig_cut_s;
    assign mismatch_cnt   = mismatch_cnt_r;
    assign first_fail_idx = first_fail_idx_r;

endmodule : misr_ora

// File: tb/tb_misr_ora.sv
// -----------------------------------------------------------------------------
// tb_misr_ora
// Directed self-checking bench for misr_ora with OUT_BITS=4, PAT_CNT=4,
// POLY=3, SEED=0. Expected signatures are hand-computed.
// -----------------------------------------------------------------------------
module tb_misr_ora;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [3:0] CUT_OP;
    logic [3:0] FF_OP;
    logic       busy;
    logic       done;
    logic       RES;
    logic       ALIAS;
    logic [3:0] SIG;
    logic [2:0] mismatch_cnt;
    logic [1:0] first_fail_idx;

    int total;
    int bad;

    misr_ora #(
        .OUT_BITS (4),
        .PAT_CNT  (4),
        .POLY     (32'h3),
        .SEED     (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .CUT_OP         (CUT_OP),
        .FF_OP          (FF_OP),
        .busy           (busy),
        .done           (done),
        .RES            (RES),
        .ALIAS          (ALIAS),
        .SIG            (SIG),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail_idx (first_fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle for sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] cut, input logic [3:0] ff);
        in_valid = 1'b1;
        CUT_OP   = cut;
        FF_OP    = ff;
        step();
        in_valid = 1'b0;
        CUT_OP   = 4'hF;
        FF_OP    = 4'h0;
    endtask

    task automatic check_result(input string tag, input logic [3:0] sig, input logic res,
                                input logic alias_v, input logic [2:0] mm, input logic [1:0] ffi);
        chk({tag, "_done"},  32'(done),           32'd1);
        chk({tag, "_busy"},  32'(busy),           32'd0);
        chk({tag, "_sig"},   32'(SIG),            32'(sig));
        chk({tag, "_res"},   32'(RES),            32'(res));
        chk({tag, "_alias"}, 32'(ALIAS),          32'(alias_v));
        chk({tag, "_mm"},    32'(mismatch_cnt),   32'(mm));
        chk({tag, "_ffi"},   32'(first_fail_idx), 32'(ffi));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        CUT_OP   = 4'h0;
        FF_OP    = 4'h0;
        #1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_done",  32'(done),           32'd0);
        chk("rst_res",   32'(RES),            32'd0);
        chk("rst_alias", 32'(ALIAS),          32'd0);
        chk("rst_sig",   32'(SIG),            32'd0);
        chk("rst_mm",    32'(mismatch_cnt),   32'd0);
        chk("rst_ffi",   32'(first_fail_idx), 32'd0);

        // Case 1: clean session, start-cycle in_valid must be ignored
        in_valid = 1'b1;
        CUT_OP   = 4'h9;
        FF_OP    = 4'h9;
        do_start();
        in_valid = 1'b0;
        chk("c1_busy_start", 32'(busy), 32'd1);
        chk("c1_sig_start",  32'(SIG),  32'd0);
        beat(4'h1, 4'h1);
        chk("c1_sig_b0", 32'(SIG), 32'h1);
        beat(4'h2, 4'h2);
        beat(4'h3, 4'h3);
        chk("c1_sig_b2", 32'(SIG), 32'h3);
        beat(4'h4, 4'h4);
        chk("c1_done_early", 32'(done), 32'd0);
        chk("c1_busy_cmp",   32'(busy), 32'd1);
        step();
        check_result("c1", 4'h2, 1'b0, 1'b0, 3'd0, 2'd0);
        step();
        chk("c1_done_held", 32'(done), 32'd1);

        // Case 2: one mismatch at beat 1 -> signatures differ
        do_start();
        chk("c2_done_clr", 32'(done), 32'd0);
        chk("c2_busy",     32'(busy), 32'd1);
        beat(4'h1, 4'h1);
        beat(4'h3, 4'h2);
        chk("c2_mm_live",  32'(mismatch_cnt),   32'd1);
        chk("c2_ffi_live", 32'(first_fail_idx), 32'd1);
        beat(4'h3, 4'h3);
        beat(4'h4, 4'h4);
        step();
        check_result("c2", 4'h6, 1'b1, 1'b0, 3'd1, 2'd1);

        // Case 3: aliasing, with a start pulse during RUN that must be ignored
        do_start();
        chk("c3_res_clr", 32'(RES),          32'd0);
        chk("c3_mm_clr",  32'(mismatch_cnt), 32'd0);
        beat(4'h1, 4'h1);
        beat(4'h2, 4'h2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("c3_start_ign_busy", 32'(busy), 32'd1);
        chk("c3_start_ign_sig",  32'(SIG),  32'd0);
        beat(4'h2, 4'h3);
        beat(4'h6, 4'h4);
        step();
        check_result("c3", 4'h2, 1'b0, 1'b1, 3'd2, 2'd2);

        // Case 4: case 1 with a 3-cycle stall between beats 2 and 3
        do_start();
        beat(4'h1, 4'h1);
        beat(4'h2, 4'h2);
        step();
        step();
        step();
        chk("c4_stall_busy", 32'(busy), 32'd1);
        chk("c4_stall_sig",  32'(SIG),  32'd0);
        beat(4'h3, 4'h3);
        beat(4'h4, 4'h4);
        chk("c4_done_early", 32'(done), 32'd0);
        step();
        check_result("c4", 4'h2, 1'b0, 1'b0, 3'd0, 2'd0);

        // Case 5: reset mid-session abandons it, then a clean rerun
        do_start();
        beat(4'h1, 4'h5);
        beat(4'h2, 4'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("c5_busy",  32'(busy),           32'd0);
        chk("c5_done",  32'(done),           32'd0);
        chk("c5_res",   32'(RES),            32'd0);
        chk("c5_sig",   32'(SIG),            32'd0);
        chk("c5_mm",    32'(mismatch_cnt),   32'd0);
        chk("c5_ffi",   32'(first_fail_idx), 32'd0);
        beat(4'h7, 4'h1);
        chk("c5_idle_busy", 32'(busy), 32'd0);
        chk("c5_idle_mm",   32'(mismatch_cnt), 32'd0);
        do_start();
        beat(4'h1, 4'h1);
        beat(4'h2, 4'h2);
        beat(4'h3, 4'h3);
        beat(4'h4, 4'h4);
        step();
        check_result("c5", 4'h2, 1'b0, 1'b0, 3'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_misr_ora
